// File: rtl/sample_packer_if.sv
// Sample input and four-phase req/ack word output of the sample packer.
// master drives samples and ack; slave (the packer) drives req, data and status.
interface sample_packer_if #(
    parameter int unsigned SAMPLE_W = 4,
    parameter int unsigned NSAMP    = 2
);
    localparam int unsigned MSG_W = SAMPLE_W * NSAMP;

    logic                en;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample;
    logic                ack;
    logic                req;
    logic [MSG_W-1:0]    data_out;
    logic                overflow;
    logic [7:0]          drop_cnt;

    modport master (
        output en, sample_valid, sample, ack,
        input  req, data_out, overflow, drop_cnt
    );

    modport slave (
        input  en, sample_valid, sample, ack,
        output req, data_out, overflow, drop_cnt
    );
endinterface

// File: rtl/sample_packer.sv
// Packs NSAMP ADC samples LSB-first into one message word and offers it
// downstream over a four-phase req/ack handshake. One completed word can be
// held while a handshake is in flight; further samples are dropped and counted.
module sample_packer #(
    parameter int unsigned SAMPLE_W = 4,
    parameter int unsigned NSAMP    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    sample_packer_if.slave  pk
);
    localparam int unsigned MSG_W  = SAMPLE_W * NSAMP;
    localparam int unsigned SLOT_W = (NSAMP > 1) ? $clog2(NSAMP) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSAMP - 1);

    typedef enum logic [1:0] {
        H_IDLE,
        H_REQ,
        H_REL
    } hs_state_e;

    hs_state_e          state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [MSG_W-1:0]   pack_q, pack_d;
    logic               pack_full_q, pack_full_d;
    logic [MSG_W-1:0]   data_out_q, data_out_d;
    logic               req_q, req_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic               take;
    logic               load_held;
    logic               accept;
    logic               drop;
    logic [MSG_W-1:0]   word;

    // Next-state: sample accept/drop, word completion, handshake progression.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        pack_d      = pack_q;
        pack_full_d = pack_full_q;
        data_out_d  = data_out_q;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;

        take      = pk.en & pk.sample_valid;
        // A held word is released the moment the handshake is idle; the same
        // cycle may still accept a new sample as slot 0 of the next word.
        load_held = (state_q == H_IDLE) & pack_full_q;
        accept    = take & (~pack_full_q | load_held);
        drop      = take & pack_full_q & ~load_held;

        word = pack_q;
        for (int unsigned k = 0; k < NSAMP; k++) begin
            if (slot_q == SLOT_W'(k)) begin
                word[k*SAMPLE_W +: SAMPLE_W] = pk.sample;
            end
        end

        if (load_held) begin
            data_out_d  = pack_q;
            pack_full_d = 1'b0;
            state_d     = H_REQ;
        end

        if (accept) begin
            pack_d = word;
            if (slot_q == LAST_SLOT) begin
                slot_d = '0;
                if (state_q == H_IDLE) begin
                    data_out_d = word;
                    state_d    = H_REQ;
                end else begin
                    pack_full_d = 1'b1;
                end
            end else begin
                slot_d = slot_q + SLOT_W'(1);
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end

        case (state_q)
            H_REQ:   if (pk.ack)  state_d = H_REL;
            H_REL:   if (!pk.ack) state_d = H_IDLE;
            default: ;
        endcase

        req_d = (state_d == H_REQ);
    end

    // Register all state; synchronous active-low reset abandons any handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= H_IDLE;
            slot_q      <= '0;
            pack_q      <= '0;
            pack_full_q <= 1'b0;
            data_out_q  <= '0;
            req_q       <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            pack_q      <= pack_d;
            pack_full_q <= pack_full_d;
            data_out_q  <= data_out_d;
            req_q       <= req_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign pk.req      = req_q;
    assign pk.data_out = data_out_q;
    assign pk.overflow = overflow_q;
    assign pk.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_sample_packer.sv
// Self-checking bench for sample_packer: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_sample_packer;
    localparam int unsigned SW = 4;
    localparam int unsigned NS = 2;
    localparam int unsigned MW = SW * NS;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sample_packer_if #(.SAMPLE_W(SW), .NSAMP(NS)) bus ();

    sample_packer #(.SAMPLE_W(SW), .NSAMP(NS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pk    (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: samples collected in a queue, one optional held word,
    // handshake phase 0 = idle, 1 = requesting, 2 = waiting for ack release.
    logic [SW-1:0] m_parts[$];
    logic [MW-1:0] m_held;
    bit            m_held_v;
    logic [MW-1:0] m_out;
    int            m_phase;
    bit            m_ovf;
    int            m_drop;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        int  ph;
        bit  take;
        logic [MW-1:0] w;
        ph   = m_phase;
        take = bus.en && bus.sample_valid;
        if (!rst_n) begin
            m_parts.delete();
            m_held   = '0;
            m_held_v = 0;
            m_out    = '0;
            m_phase  = 0;
            m_ovf    = 0;
            m_drop   = 0;
            return;
        end
        if (ph == 0 && m_held_v) begin
            m_out    = m_held;
            m_held_v = 0;
            m_phase  = 1;
            if (take) m_parts.push_back(bus.sample);
        end else if (take) begin
            if (m_held_v) begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end else begin
                m_parts.push_back(bus.sample);
                if (m_parts.size() == NS) begin
                    w = '0;
                    for (int k = 0; k < NS; k++) w = w | (MW'(m_parts[k]) << (k * SW));
                    m_parts.delete();
                    if (ph == 0) begin
                        m_out   = w;
                        m_phase = 1;
                    end else begin
                        m_held   = w;
                        m_held_v = 1;
                    end
                end
            end
        end
        if (ph == 1 && bus.ack) m_phase = 2;
        else if (ph == 2 && !bus.ack) m_phase = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_val("req",      32'(bus.req),      32'(m_phase == 1));
        check_val("data_out", 32'(bus.data_out), 32'(m_out));
        check_val("overflow", 32'(bus.overflow), 32'(m_ovf));
        check_val("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    endtask

    task automatic put(input bit e, input bit v, input logic [SW-1:0] s);
        bus.en           = e;
        bus.sample_valid = v;
        bus.sample       = s;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.ack = 1'b0;
        put(0, 0, '0);
        step();
        step();
        check_val("rst_req",  32'(bus.req),      0);
        check_val("rst_data", 32'(bus.data_out), 0);
        check_val("rst_drop", 32'(bus.drop_cnt), 0);
        rst_n = 1'b1;

        // Basic pack and full handshake.
        put(1, 1, 4'h3); step();
        put(1, 1, 4'h5); step();
        check_val("basic_req",  32'(bus.req),      1);
        check_val("basic_data", 32'(bus.data_out), 32'h53);
        put(0, 0, '0);
        repeat (3) step();
        check_val("basic_hold", 32'(bus.req), 1);
        bus.ack = 1'b1; step();
        check_val("hs_req_low", 32'(bus.req), 0);
        bus.ack = 1'b0; step();
        put(1, 1, 4'hA); step();
        put(1, 1, 4'hC); step();
        put(0, 0, '0);
        check_val("hs_data2", 32'(bus.data_out), 32'hCA);
        check_val("hs_req2",  32'(bus.req),      1);
        bus.ack = 1'b1; step();
        bus.ack = 1'b0; step();

        // Backpressure, then drop-counter saturation.
        do_reset();
        put(1, 1, 4'h3); step();
        put(1, 1, 4'h5); step();
        put(1, 1, 4'h1); step();
        put(1, 1, 4'h2); step();
        put(1, 1, 4'h7); step();
        put(1, 1, 4'h9); step();
        check_val("bp_data", 32'(bus.data_out), 32'h53);
        check_val("bp_drop", 32'(bus.drop_cnt), 2);
        check_val("bp_ovf",  32'(bus.overflow), 1);
        repeat (300) begin
            put(1, 1, 4'($urandom));
            step();
        end
        check_val("sat_drop", 32'(bus.drop_cnt), 255);
        repeat (3) step();
        check_val("sat_stable", 32'(bus.drop_cnt), 255);
        check_val("sat_ovf",    32'(bus.overflow), 1);
        put(0, 0, '0);
        bus.ack = 1'b1; step();
        bus.ack = 1'b0; step();
        step();
        check_val("held_data", 32'(bus.data_out), 32'h21);
        check_val("held_req",  32'(bus.req),      1);
        bus.ack = 1'b1; step();
        bus.ack = 1'b0; step();

        // Enable gating.
        do_reset();
        put(1, 1, 4'h4); step();
        put(0, 1, 4'h6); step();
        put(1, 1, 4'h8); step();
        put(0, 0, '0);
        check_val("en_data", 32'(bus.data_out), 32'h84);
        check_val("en_drop", 32'(bus.drop_cnt), 0);

        // Mid-handshake reset; samples under reset are ignored.
        rst_n = 1'b0;
        put(1, 1, 4'h7);
        step();
        rst_n = 1'b1;
        check_val("mrst_req",  32'(bus.req),      0);
        check_val("mrst_data", 32'(bus.data_out), 0);
        check_val("mrst_drop", 32'(bus.drop_cnt), 0);
        put(1, 1, 4'h1); step();
        put(1, 1, 4'hE); step();
        put(0, 0, '0);
        check_val("mrst_fresh", 32'(bus.data_out), 32'hE1);

        // Half-rate samples with a zero-latency responder must never drop.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.ack = bus.req;
            put(1, (i % 2) == 0, 4'($urandom));
            step();
        end
        bus.ack = bus.req;
        put(0, 0, '0);
        check_val("rate_nodrop", 32'(bus.drop_cnt), 0);
        check_val("rate_noovf",  32'(bus.overflow), 0);

        // Randomized traffic with mixed ack behaviour and occasional resets.
        do_reset();
        for (int seg = 0; seg < 15; seg++) begin
            int ack_mode;
            int vld_pct;
            ack_mode = int'($urandom_range(0, 2));
            vld_pct  = int'($urandom_range(20, 100));
            for (int i = 0; i < 200; i++) begin
                rst_n = ($urandom_range(0, 199) != 0);
                case (ack_mode)
                    0:       bus.ack = bus.req;
                    1:       bus.ack = 1'($urandom);
                    default: bus.ack = ($urandom_range(0, 9) < 2) ? 1'b1 : (bus.req ? 1'b0 : bus.ack);
                endcase
                put($urandom_range(0, 9) != 0, $urandom_range(1, 100) <= vld_pct, 4'($urandom));
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/sample_packer.md
SAMPLE_PACKER -- requirements
Module: sample_packer

Upstream stage of the FEC chain. Packs ADC samples into message words and delivers them over the chain's four-phase req/ack handshake.

Interface
REQ-001 Parameter SAMPLE_W, default 4, SHALL set the ADC sample width in bits.
REQ-002 Parameter NSAMP, default 2, SHALL set the number of samples packed per message word (legal range 2..8).
REQ-003 Derived width MSG_W = SAMPLE_W*NSAMP (8 at defaults) SHALL equal the message_data_t width consumed downstream.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-007 en  input  1  sample-accept enable.
REQ-008 sample_valid  input  1  sample strobe, one sample per cycle when high.
REQ-009 sample  input  SAMPLE_W  ADC sample value.
REQ-010 ack  input  1  downstream acknowledge.
REQ-011 req  output  1  word-available request.
REQ-012 data_out  output  MSG_W  packed word, stable while req=1 and until ack falls.
REQ-013 overflow  output  1  sticky flag, set on any dropped sample.
REQ-014 drop_cnt  output  8  count of dropped samples, saturating at 255.

Function
REQ-015 The pack register SHALL fill LSB-first: sample k of a word occupies bits [k*SAMPLE_W +: SAMPLE_W].
REQ-016 A sample SHALL be accepted only when en=1, sample_valid=1 and pack_full=0; the slot counter SHALL increment from 0 to NSAMP-1, then wrap to 0.
REQ-017 When en=0, sample_valid SHALL be ignored: no accept, no drop. The partial word and the slot counter SHALL be retained.
REQ-018 The handshake FSM SHALL have three states:
- H_IDLE: req=0.
- H_REQ: req=1; go to H_REL when ack=1.
- H_REL: req=0; go to H_IDLE when ack=0.
REQ-019 When the NSAMP-th sample is accepted in H_IDLE, the completed word SHALL load data_out and the FSM SHALL enter H_REQ on the same edge, so req=1 is seen the cycle after the final sample edge.
REQ-020 When the NSAMP-th sample is accepted outside H_IDLE, the word SHALL be held in the pack register and pack_full SHALL be set to 1.
REQ-021 In H_IDLE with pack_full=1, the held word SHALL load data_out, pack_full SHALL clear, and the FSM SHALL enter H_REQ on one edge.
- A sample valid on that same cycle SHALL be accepted as slot 0 of the next word.
REQ-022 A sample with en=1, sample_valid=1 and pack_full=1 SHALL be dropped: overflow set to 1, drop_cnt incremented unless already 255.
REQ-023 data_out SHALL change only on a load into H_REQ (REQ-019 or REQ-021); it SHALL hold its value through H_REQ and H_REL.
REQ-024 ack=1 observed in H_IDLE SHALL be ignored (no state change).
REQ-025 Sustained throughput SHALL be one word per 4 cycles minimum with a zero-latency ack responder; there SHALL be no drops when the sample rate is at most 1/2 per cycle at NSAMP=2 with that responder.

Reset
REQ-026 While rst_n=0 at a clk edge, the block SHALL set:
- req=0, data_out=0, overflow=0, drop_cnt=0;
- FSM=H_IDLE, slot counter=0, pack_full=0, pack register=0.
REQ-027 Reset asserted mid-handshake SHALL abandon the word immediately: req=0 on the next cycle, with no wait for ack to fall.
REQ-028 Samples presented while rst_n=0 SHALL be neither accepted nor counted.

Verification
REQ-029 Basic pack (defaults): samples 0x3, 0x5 on consecutive cycles, ack held 0 -> req=1 one cycle after 0x5, data_out=0x53; req held until ack=1.
REQ-030 Full handshake: from REQ-029, raise ack -> req=0 next cycle; drop ack -> FSM returns to H_IDLE; next pair 0xA, 0xC -> data_out=0xCA.
REQ-031 Backpressure: ack held 0 after word 0x53 while streaming 0x1, 0x2, 0x7, 0x9 -> 0x21 held with pack_full=1; 0x7 and 0x9 dropped; overflow=1, drop_cnt=2.
REQ-032 Saturation: 300 drops forced -> drop_cnt=255 and stable; overflow=1.
REQ-033 Enable gating: sample 0x4 with en=1, then 0x6 with en=0, then 0x8 with en=1 -> data_out=0x84 and no drop counted.
REQ-034 Mid-handshake reset: rst_n=0 for one cycle while req=1 -> req=0, data_out=0, drop_cnt=0; the next two samples form a fresh word.
